// File: rtl/wb_slave_mem.sv
// Wishbone classic (B3) slave memory with a fixed number of wait states and byte-lane writes.
// Define WB_SLAVE_MEM_ERR_EN to terminate out-of-range word indices with err_o instead of wrapping.
module wb_slave_mem #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   adr_i,
    input  logic [DATA_WIDTH-1:0]   dat_i,
    output logic [DATA_WIDTH-1:0]   dat_o,
    input  logic [DATA_WIDTH/8-1:0] sel_i,
    input  logic                    we_i,
    input  logic                    cyc_i,
    input  logic                    stb_i,
    output logic                    ack_o,
    output logic                    err_o
);
    localparam int NB        = DATA_WIDTH / 8;
    localparam int LANE_BITS = (NB > 1) ? $clog2(NB) : 0;
    localparam int IDX_BITS  = $clog2(DEPTH);
    localparam bit NO_WAIT   = (WAIT_STATES == 0);
    localparam logic [3:0] CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    state_t                state_reg;
    logic [3:0]            cnt_reg;
    logic [ADDR_WIDTH-1:0] adr_reg;
    logic [DATA_WIDTH-1:0] dat_reg;
    logic [NB-1:0]         sel_reg;
    logic                  we_reg;
    logic                  ack_reg;
    logic                  err_reg;

    logic                  req;
    logic                  in_idle;
    logic [ADDR_WIDTH-1:0] acc_adr;
    logic [DATA_WIDTH-1:0] acc_dat;
    logic [NB-1:0]         acc_sel;
    logic                  acc_we;
    logic [IDX_BITS-1:0]   idx;
    logic                  addr_err;
    logic                  go_ack;
    logic                  wr_en;
    logic                  rd_en;
    logic                  unused_addr;

    assign req     = cyc_i & stb_i;
    assign in_idle = (state_reg == S_IDLE);

    // With no wait states the memory access happens on the same edge that samples the
    // request, so the live bus is used in IDLE and the latched copy afterwards.
    assign acc_adr = in_idle ? adr_i : adr_reg;
    assign acc_dat = in_idle ? dat_i : dat_reg;
    assign acc_sel = in_idle ? sel_i : sel_reg;
    assign acc_we  = in_idle ? we_i  : we_reg;
    assign idx     = acc_adr[LANE_BITS +: IDX_BITS];

`ifdef WB_SLAVE_MEM_ERR_EN
    assign addr_err = |acc_adr[ADDR_WIDTH-1:LANE_BITS+IDX_BITS];
`else
    assign addr_err = 1'b0;
`endif

    // Lane-offset bits (and, when wrapping, the upper bits) do not select storage.
    assign unused_addr = ^acc_adr;

    assign go_ack = rst & req & ((in_idle & NO_WAIT) | ((state_reg == S_WAIT) & (cnt_reg == 4'd0)));
    assign wr_en  = go_ack & acc_we & ~addr_err;
    assign rd_en  = go_ack & ~acc_we & ~addr_err;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= S_IDLE;
            cnt_reg   <= 4'd0;
            ack_reg   <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            ack_reg <= 1'b0;
            err_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (req) begin
                        adr_reg <= adr_i;
                        dat_reg <= dat_i;
                        sel_reg <= sel_i;
                        we_reg  <= we_i;
                        if (NO_WAIT) begin
                            state_reg <= S_ACK;
                            ack_reg   <= ~addr_err;
                            err_reg   <= addr_err;
                        end else begin
                            cnt_reg   <= CNT_INIT;
                            state_reg <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (!req) begin
                        state_reg <= S_IDLE;
                    end else if (cnt_reg == 4'd0) begin
                        state_reg <= S_ACK;
                        ack_reg   <= ~addr_err;
                        err_reg   <= addr_err;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                S_ACK:   state_reg <= S_IDLE;
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign ack_o = ack_reg;
    assign err_o = err_reg;

    // One byte-wide RAM per lane keeps byte enables trivial and each array single-writer.
    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
        logic [7:0] mem [DEPTH];
        logic [7:0] rd_reg;

        always_ff @(posedge clk) begin
            if (wr_en && acc_sel[gi]) begin
                mem[idx] <= acc_dat[gi*8 +: 8];
            end
        end

        always_ff @(posedge clk) begin
            if (!rst) begin
                rd_reg <= 8'd0;
            end else if (rd_en) begin
                rd_reg <= mem[idx];
            end
        end

        assign dat_o[gi*8 +: 8] = rd_reg;
    end
endmodule

// File: tb/tb_wb_slave_mem.sv
// Bench for wb_slave_mem: three instances (1, 3 and 0 wait states) driven by directed
// transfers; expected terminations are queued and checked by an independent monitor.
module tb_wb_slave_mem;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] adr   [3];
    logic [31:0] dat_i [3];
    logic [31:0] dat_o [3];
    logic [3:0]  sel   [3];
    logic        we    [3];
    logic        cyc   [3];
    logic        stb   [3];
    logic        ack   [3];
    logic        err   [3];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        wb_slave_mem #(
            .DATA_WIDTH (32),
            .ADDR_WIDTH (32),
            .DEPTH      (256),
            .WAIT_STATES(gi == 0 ? 1 : (gi == 1 ? 3 : 0))
        ) u_dut (
            .clk  (clk),
            .rst  (rst),
            .adr_i(adr[gi]),
            .dat_i(dat_i[gi]),
            .dat_o(dat_o[gi]),
            .sel_i(sel[gi]),
            .we_i (we[gi]),
            .cyc_i(cyc[gi]),
            .stb_i(stb[gi]),
            .ack_o(ack[gi]),
            .err_o(err[gi])
        );
    end

    typedef struct {
        int          inst;
        bit          is_err;
        bit          chk;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];
    exp_t got;
    int   total   = 0;
    int   bad     = 0;
    int   cyc_cnt = 0;
    bit   prev_ack[3];

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    function automatic int ws_of(int i);
        return (i == 0) ? 1 : ((i == 1) ? 3 : 0);
    endfunction

    // Monitor: every termination must match the oldest queued expectation, including its cycle.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (ack[i] || err[i]) begin
                total++;
                $display("term inst=%0d ack=%0b err=%0b dat=%h cyc=%0d", i, ack[i], err[i], dat_o[i], cyc_cnt);
                if (sb_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_term inst=%0d got ack=%0b err=%0b want none", i, ack[i], err[i]);
                end else begin
                    got = sb_q.pop_front();
                    if (got.inst != i || got.cyc != cyc_cnt || err[i] !== got.is_err ||
                        ack[i] !== !got.is_err || prev_ack[i] || (got.chk && dat_o[i] !== got.data)) begin
                        bad++;
                        $display("FAIL term inst=%0d got ack=%0b err=%0b dat=%h cyc=%0d prev_ack=%0b want inst=%0d err=%0b dat=%h(chk=%0b) cyc=%0d",
                                 i, ack[i], err[i], dat_o[i], cyc_cnt, prev_ack[i],
                                 got.inst, got.is_err, got.data, got.chk, got.cyc);
                    end
                end
            end
            prev_ack[i] = ack[i];
        end
    end

    task automatic push(input int i, input bit e, input bit c, input logic [31:0] d);
        exp_t x;
        x.inst   = i;
        x.is_err = e;
        x.chk    = c;
        x.data   = d;
        x.cyc    = cyc_cnt + ws_of(i) + 1;
        sb_q.push_back(x);
    endtask

    task automatic wait_term(input int i);
        bit seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (ack[i] || err[i]) seen = 1'b1;
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL timeout inst=%0d got no_termination want ack_or_err", i);
            sb_q.delete();
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the termination with the strobe still up.
    task automatic xfer(input int i, input bit w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input bit e, input bit c, input logic [31:0] ed);
        adr[i]   = a;
        dat_i[i] = d;
        sel[i]   = s;
        we[i]    = w;
        cyc[i]   = 1'b1;
        stb[i]   = 1'b1;
        push(i, e, c, ed);
        wait_term(i);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int i, input int n);
        cyc[i] = 1'b0;
        stb[i] = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [31:0] b2b [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};

    initial begin
        #500000;
        $display("FAIL watchdog got no_finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit [2:0] done;
        bit [2:0] pend;
        int       n_term;

        for (int i = 0; i < 3; i++) begin
            adr[i] = 32'h0; dat_i[i] = 32'h0; sel[i] = 4'hF; we[i] = 1'b0;
            cyc[i] = 1'b1;  stb[i] = 1'b1;  prev_ack[i] = 1'b0;
        end

        // Reset held with a pending strobe: no terminations, dat_o cleared.
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                total++;
                if (ack[i] !== 1'b0 || err[i] !== 1'b0 || dat_o[i] !== 32'h0) begin
                    bad++;
                    $display("FAIL reset inst=%0d got ack=%0b err=%0b dat=%h want 0 0 00000000",
                             i, ack[i], err[i], dat_o[i]);
                end
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        push(2, 1'b0, 1'b0, 32'h0);
        push(0, 1'b0, 1'b0, 32'h0);
        push(1, 1'b0, 1'b0, 32'h0);
        done = 3'b000;
        for (int k = 0; k < 20 && done != 3'b111; k++) begin
            pend = 3'b000;
            @(negedge clk);
            for (int i = 0; i < 3; i++) if (!done[i] && (ack[i] || err[i])) pend[i] = 1'b1;
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) if (pend[i]) begin cyc[i] = 1'b0; stb[i] = 1'b0; done[i] = 1'b1; end
        end
        if (done != 3'b111) begin
            total++;
            bad++;
            $display("FAIL reset_release got done=%b want 111", done);
            sb_q.delete();
        end
        repeat (2) @(posedge clk);
        #1;

        // Full-word write/read, byte lanes, sel=0 on read and write.
        for (int i = 0; i < 2; i++) begin
            xfer(i, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF,    1'b0, 1'b0, 32'h0);
            xfer(i, 1'b0, 32'h10, 32'h0,        4'hF,    1'b0, 1'b1, 32'hDEADBEEF);
            xfer(i, 1'b1, 32'h10, 32'h11223344, 4'b0101, 1'b0, 1'b0, 32'h0);
            xfer(i, 1'b0, 32'h10, 32'h0,        4'h0,    1'b0, 1'b1, 32'hDE22BE44);
            xfer(i, 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0,    1'b0, 1'b0, 32'h0);
            xfer(i, 1'b0, 32'h10, 32'h0,        4'hF,    1'b0, 1'b1, 32'hDE22BE44);
            idle(i, 2);
        end

        // Master abort during wait states (3 wait states): no termination, no write.
        adr[1] = 32'h10; dat_i[1] = 32'h0; sel[1] = 4'hF; we[1] = 1'b1;
        cyc[1] = 1'b1;   stb[1] = 1'b1;
        @(posedge clk);
        #1;
        cyc[1] = 1'b0;
        stb[1] = 1'b0;
        n_term = 0;
        repeat (8) begin
            @(negedge clk);
            if (ack[1] || err[1]) n_term++;
        end
        total++;
        if (n_term != 0) begin
            bad++;
            $display("FAIL abort got terminations=%0d want 0", n_term);
        end
        @(posedge clk);
        #1;
        xfer(1, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0, 1'b1, 32'hDE22BE44);

        // Bus changes during wait states are ignored.
        adr[1] = 32'h14; dat_i[1] = 32'hCAFEF00D; sel[1] = 4'hF; we[1] = 1'b1;
        cyc[1] = 1'b1;   stb[1] = 1'b1;
        push(1, 1'b0, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        adr[1] = 32'h18; dat_i[1] = 32'h0; sel[1] = 4'h0; we[1] = 1'b0;
        wait_term(1);
        @(posedge clk);
        #1;
        xfer(1, 1'b0, 32'h14, 32'h0, 4'hF, 1'b0, 1'b1, 32'hCAFEF00D);
        idle(1, 2);

        // Zero wait states, strobe held across back-to-back transfers.
        for (int k = 0; k < 4; k++) xfer(2, 1'b1, 32'(4 * k), b2b[k], 4'hF, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 4; k++) xfer(2, 1'b0, 32'(4 * k), 32'h0,  4'hF, 1'b0, 1'b1, b2b[k]);

        // Word index 256 is past the end of the array.
`ifdef WB_SLAVE_MEM_ERR_EN
        xfer(2, 1'b1, 32'h400, 32'hA5A5A5A5, 4'hF, 1'b1, 1'b1, 32'h44444444);
        xfer(2, 1'b0, 32'h400, 32'h0,        4'hF, 1'b1, 1'b1, 32'h44444444);
        xfer(2, 1'b0, 32'h0,   32'h0,        4'hF, 1'b0, 1'b1, 32'h11111111);
`else
        xfer(2, 1'b1, 32'h400, 32'hA5A5A5A5, 4'hF, 1'b0, 1'b0, 32'h0);
        xfer(2, 1'b0, 32'h0,   32'h0,        4'hF, 1'b0, 1'b1, 32'hA5A5A5A5);
        xfer(2, 1'b0, 32'h400, 32'h0,        4'hF, 1'b0, 1'b1, 32'hA5A5A5A5);
`endif
        idle(2, 4);

        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL leftover got pending=%0d want 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wb_slave_mem.md
Name: wb_slave_mem

Overview:
- Wishbone classic (B3) slave memory with programmable wait states; the slave-side consumer of the dut's Wishbone slave port.
- Connects to the signals carried by wb_slave_if in the environment top.
- Gives the dut a real, cycle-accurate target in place of a purely behavioural slave model.
- Single clock domain, byte-lane writes, optional out-of-range error response.

Parameters:
- DATA_WIDTH, 32: data bus width in bits; multiple of 8.
- ADDR_WIDTH, 32: byte-address width of adr_i.
- DEPTH, 256: number of DATA_WIDTH words stored; power of two, at least 2.
- WAIT_STATES, 1: idle cycles inserted before ack; range 0..15.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  reset; active-low, synchronous.
- adr_i  input  ADDR_WIDTH  byte address; word index = adr_i[ADDR_WIDTH-1:log2(DATA_WIDTH/8)].
- dat_i  input  DATA_WIDTH  write data.
- dat_o  output  DATA_WIDTH  read data.
- sel_i  input  DATA_WIDTH/8  byte-lane selects.
- we_i  input  1  1 = write, 0 = read.
- cyc_i  input  1  bus cycle active.
- stb_i  input  1  strobe.
- ack_o  output  1  normal termination.
- err_o  output  1  error termination (see Optional Feature).

Behaviour:
- Reset (rst==0 at a rising edge): state=IDLE, ack_o=0, err_o=0, dat_o=0, wait counter=0. Memory contents are not cleared.
- A reset asserted mid-transfer aborts the transfer, performs no write and issues no ack.
- FSM IDLE: when cyc_i&stb_i, latch adr_i/dat_i/sel_i/we_i.
  - WAIT_STATES==0: go to ACK.
  - Otherwise: load counter=WAIT_STATES-1 and go to WAIT.
- FSM WAIT: if !cyc_i or !stb_i, return to IDLE with no write and no ack (master abort). Else if counter==0, go to ACK; else decrement the counter.
- FSM ACK: exactly one cycle.
  - ack_o=1, or err_o=1 for an error response.
  - Write: for each lane b with sel_i[b]=1, update that byte of mem[index]; unselected bytes are unchanged.
  - Read: dat_o=mem[index], valid in the same cycle as ack_o.
  - Next state is IDLE.
- Latency from the request cycle to ack: WAIT_STATES+1 cycles. Minimum transfer period: WAIT_STATES+2 cycles.
- An strobe held after ack is treated as a new request, sampled in IDLE on the following cycle.
- ack_o and err_o are mutually exclusive, registered, single-cycle pulses, and never asserted outside ACK.
- dat_o holds its last value outside ACK. On writes and on error responses, dat_o keeps its previous value.
- Read with sel_i=0: returns the full word. Write with sel_i=0: no bytes change, ack still issued.
- Inputs are sampled only in IDLE. Changes to adr_i/dat_i/sel_i/we_i during WAIT are ignored.

Optional Feature:
- Macro: WB_SLAVE_MEM_ERR_EN.
- Defined:
  - A word index >= DEPTH, computed on the full upper address bits, terminates with err_o=1 and ack_o=0 in the ACK cycle.
  - The write is suppressed and dat_o is unchanged.
  - Wait states are still inserted as normal.
- Undefined:
  - The index is truncated to log2(DEPTH) bits, so the address wraps modulo DEPTH.
  - Every transfer terminates with ack_o.
  - err_o is tied to 0.

Test Plan:
- Reset check. Hold rst=0 for 3 cycles with cyc_i=stb_i=1 -> ack_o=err_o=0 and dat_o=0 throughout. After rst=1 with strobe held, the first ack_o occurs WAIT_STATES+1 cycles later.
- Basic access, WAIT_STATES=1. Write 0xDEADBEEF to adr 0x10 with sel=4'hF, then read adr 0x10 -> each ack_o comes 2 cycles after its request, and the read returns dat_o=0xDEADBEEF.
- Byte lanes. Write 0x11223344 with sel=4'b0101 over the previous word -> read returns 0xDE22BE44.
- Abort. Issue a write of 0x0 to adr 0x10 with WAIT_STATES=3 and drop stb_i after 1 cycle -> no ack_o, and mem[4] still reads 0xDE22BE44.
- Back-to-back, WAIT_STATES=0. Hold strobe for 4 reads of adr 0x0, 0x4, 0x8, 0xC -> ack_o pulses every 2nd cycle with the correct data each time, and ack_o never stays high for 2 consecutive cycles.
- Out of range, DEPTH=256, read and write to adr 0x400:
  - With WB_SLAVE_MEM_ERR_EN: err_o=1, ack_o=0, mem[0] unchanged.
  - Without it: ack_o=1, and the access aliases mem[0] (a write of 0xA5A5A5A5 reads back from adr 0x0).
